// File: rtl/nios_segments_keys_if.sv
// Avalon-MM slave bus bundle for the Nios key/switch input port.
// The CPU side drives address/strobe/data; the port returns read data with zero latency.
interface nios_segments_keys_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_segments_keys.sv
// Nios key/switch input port: per-bit 2-FF synchroniser, debounce counter,
// edge capture (write-1-to-clear) and a maskable registered level interrupt.
// Register map (word offsets): 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (W1C).
module nios_segments_keys #(
    parameter int unsigned WIDTH           = 32'd4,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd50000,
    parameter int unsigned EDGE_TYPE       = 32'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    nios_segments_keys_if.slave    bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Filters debounce events down to the edge direction that should latch a capture bit.
    // new_level is the debounced value being adopted, so 1 means a 0->1 transition.
    function automatic logic [WIDTH-1:0] qualify_edges(
        input logic [WIDTH-1:0] evt,
        input logic [WIDTH-1:0] new_level
    );
        logic [WIDTH-1:0] q;
        case (EDGE_TYPE)
            32'd0:   q = evt & new_level;
            32'd1:   q = evt & ~new_level;
            32'd2:   q = evt;
            default: q = {WIDTH{1'b0}};
        endcase
        return q;
    endfunction

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] db_r;
    logic [WIDTH-1:0] db_nxt_s;
    logic [CNT_W-1:0] cnt_r   [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] evt_s;
    logic [WIDTH-1:0] qual_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] cap_clr_s;
    logic [WIDTH-1:0] cap_nxt_s;
    logic             irq_r;
    logic             wr_s;
    logic             unused_wdata_s;

    assign wr_s           = bus.chipselect & ~bus.write_n;
    assign qual_s         = qualify_edges(evt_s, db_nxt_s);
    assign irq            = irq_r;
    assign unused_wdata_s = &{1'b0, bus.writedata};

    // Two-stage synchroniser for the asynchronous input lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: adopt sync2 only after it has disagreed for DEBOUNCE_CYCLES edges.
    always_comb begin
        db_nxt_s  = db_r;
        evt_s     = {WIDTH{1'b0}};
        cnt_nxt_s = cnt_r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_r[i] == db_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_MAX) begin
                db_nxt_s[i]  = sync2_r[i];
                cnt_nxt_s[i] = CNT_ZERO;
                evt_s[i]     = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounced level and per-bit counters; reset discards any count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_r <= {WIDTH{1'b0}};
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            db_r  <= db_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Capture next-state: a W1C clear is applied first so a coincident edge still sets the bit.
    always_comb begin
        cap_clr_s = {WIDTH{1'b0}};
        if (wr_s && (bus.address == ADDR_EDGECAP)) begin
            cap_clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            cap_clr_s = {WIDTH{1'b0}};
        end
        cap_nxt_s = (cap_r & ~cap_clr_s) | qual_s;
    end

    // Interrupt mask, edge capture and registered interrupt level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {WIDTH{1'b0}};
            cap_r  <= {WIDTH{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            if (wr_s && (bus.address == ADDR_IRQMASK)) begin
                mask_r <= bus.writedata[WIDTH-1:0];
            end
            cap_r <= cap_nxt_s;
            irq_r <= |(cap_r & mask_r);
        end
    end

    // Zero-latency read mux; independent of chipselect, upper bits read as zero.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = 32'(db_r);
            ADDR_RSVD:    bus.readdata = 32'd0;
            ADDR_IRQMASK: bus.readdata = 32'(mask_r);
            ADDR_EDGECAP: bus.readdata = 32'(cap_r);
            default:      bus.readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nios_segments_keys.sv
// Scoreboard bench for nios_segments_keys (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
// Stimulus pushes expected read data / irq levels; a negedge monitor pops and compares.
module tb_nios_segments_keys;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RSVD = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_CAP  = 2'd3;

    typedef struct {
        string       name;
        bit          use_rd;
        logic [31:0] rd_exp;
        bit          use_irq;
        logic        irq_exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_port = 4'h0;
    logic       irq;
    bit         chk_valid = 1'b0;
    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;

    nios_segments_keys_if bus();

    nios_segments_keys #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: whenever a check is presented, pop the expected entry and compare.
    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty: check presented with no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.use_rd) begin
                    n_chk++;
                    if (bus.readdata !== e.rd_exp) begin
                        n_fail++;
                        $display("FAIL %s readdata actual=%h required=%h", e.name, bus.readdata, e.rd_exp);
                    end
                end
                if (e.use_irq) begin
                    n_chk++;
                    if (irq !== e.irq_exp) begin
                        n_fail++;
                        $display("FAIL %s irq actual=%b required=%b", e.name, irq, e.irq_exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one check in the current cycle, then advances to just after the next edge.
    task automatic tick_chk(input string name, input bit use_rd, input logic [1:0] a,
                            input logic [31:0] rd_exp, input bit use_irq, input logic irq_exp);
        exp_t e;
        if (use_rd) bus.address = a;
        e.name    = name;
        e.use_rd  = use_rd;
        e.rd_exp  = rd_exp;
        e.use_irq = use_irq;
        e.irq_exp = irq_exp;
        sb.push_back(e);
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Single-cycle bus write; the register updates at the edge ending this cycle.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        tick();

        // 1. Reset state: all registers read 0, irq low.
        tick_chk("rst_data", 1'b1, A_DATA, 32'h0, 1'b1, 1'b0);
        tick_chk("rst_rsvd", 1'b1, A_RSVD, 32'h0, 1'b0, 1'b0);
        tick_chk("rst_mask", 1'b1, A_MASK, 32'h0, 1'b0, 1'b0);
        tick_chk("rst_cap",  1'b1, A_CAP,  32'h0, 1'b1, 1'b0);

        // 2. Debounce latency: DATA becomes 1 five edges after the first sampling edge.
        reset   = 1'b0;
        in_port = 4'b0001;
        for (int j = 0; j < 8; j++) begin
            tick_chk($sformatf("lat_data_%0d", j), 1'b1, A_DATA, (j >= 6) ? 32'h1 : 32'h0, 1'b1, 1'b0);
        end
        tick_chk("lat_cap", 1'b1, A_CAP, 32'h0, 1'b0, 1'b0);

        // 3. Glitch rejection, then an accepted 6-cycle low pulse on bit2.
        in_port = 4'hF;
        for (int j = 0; j < 8; j++) tick();
        tick_chk("all_high", 1'b1, A_DATA, 32'hF, 1'b0, 1'b0);
        in_port = 4'hB;
        for (int j = 0; j < 3; j++) tick_chk($sformatf("glitch_a_%0d", j), 1'b1, A_DATA, 32'hF, 1'b0, 1'b0);
        in_port = 4'hF;
        for (int j = 0; j < 5; j++) tick_chk($sformatf("glitch_b_%0d", j), 1'b1, A_DATA, 32'hF, 1'b0, 1'b0);
        tick_chk("glitch_cap", 1'b1, A_CAP, 32'h0, 1'b0, 1'b0);
        in_port = 4'hB;
        for (int j = 0; j < 6; j++) tick_chk($sformatf("pulse_a_%0d", j), 1'b1, A_DATA, 32'hF, 1'b0, 1'b0);
        in_port = 4'hF;
        for (int j = 6; j < 14; j++) begin
            tick_chk($sformatf("pulse_b_%0d", j), 1'b1, A_DATA, (j < 12) ? 32'hB : 32'hF, 1'b0, 1'b0);
        end
        tick_chk("pulse_cap", 1'b1, A_CAP, 32'h4, 1'b1, 1'b0);
        wr(A_CAP, 32'h4);
        tick_chk("pulse_clr", 1'b1, A_CAP, 32'h0, 1'b0, 1'b0);

        // 4. IRQ path: irq one cycle after cap[2]; W1C clears cap, irq falls next cycle.
        wr(A_MASK, 32'h4);
        in_port = 4'hB;
        for (int j = 0; j < 9; j++) begin
            tick_chk($sformatf("irq_rise_%0d", j), 1'b1, A_CAP, (j >= 6) ? 32'h4 : 32'h0, 1'b1, (j >= 7));
        end
        tick_chk("mask_rd", 1'b1, A_MASK, 32'h4, 1'b1, 1'b1);
        wr(A_CAP, 32'h4);
        tick_chk("w1c_cap", 1'b1, A_CAP, 32'h0, 1'b1, 1'b1);
        tick_chk("w1c_irq", 1'b1, A_CAP, 32'h0, 1'b1, 1'b0);
        in_port = 4'hF;
        for (int j = 0; j < 7; j++) tick();
        wr(A_MASK, 32'h0);
        in_port = 4'hB;
        for (int j = 0; j < 8; j++) begin
            tick_chk($sformatf("masked_%0d", j), 1'b1, A_CAP, (j >= 6) ? 32'h4 : 32'h0, 1'b1, 1'b0);
        end
        wr(A_CAP, 32'h4);
        in_port = 4'hF;
        for (int j = 0; j < 7; j++) tick();
        tick_chk("settle_f", 1'b1, A_DATA, 32'hF, 1'b1, 1'b0);

        // 5. W1C of bit1 on the same edge its debounced fall lands: set wins.
        wr(A_MASK, 32'h2);
        in_port = 4'hD;
        for (int j = 0; j < 5; j++) tick();
        wr(A_CAP, 32'h2);
        tick_chk("collide_cap", 1'b1, A_CAP, 32'h2, 1'b1, 1'b0);
        tick_chk("collide_irq", 1'b1, A_DATA, 32'hD, 1'b1, 1'b1);
        wr(A_DATA, 32'h0);
        tick_chk("ro_data", 1'b1, A_DATA, 32'hD, 1'b0, 1'b0);
        wr(A_RSVD, 32'hFFFF_FFFF);
        tick_chk("ro_rsvd", 1'b1, A_RSVD, 32'h0, 1'b1, 1'b1);

        // 6 / 1. Async reset mid-cycle while irq is high and bit0 is mid-debounce.
        in_port = 4'hC;
        for (int j = 0; j < 4; j++) tick();
        reset = 1'b1;
        tick_chk("arst_irq",  1'b1, A_DATA, 32'h0, 1'b1, 1'b0);
        tick_chk("arst_mask", 1'b1, A_MASK, 32'h0, 1'b1, 1'b0);
        tick_chk("arst_cap",  1'b1, A_CAP,  32'h0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick_chk($sformatf("restart_%0d", j), 1'b1, A_DATA, (j >= 6) ? 32'hC : 32'h0, 1'b1, 1'b0);
        end
        tick_chk("restart_cap", 1'b1, A_CAP, 32'h0, 1'b1, 1'b0);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: entries left actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
